// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt entry and ERET return sequencer for the pipeline front end.
// Ports:
//   clk, reset (async, active low)
//   exc_req     synchronous invalid-opcode exception from decode (1-cycle)
//   exc_pc      PC of the faulting instruction / PC sampled for an interrupt
//   ext_irq     level external interrupt request, masked while the handler runs
//   eret        ERET executing (1-cycle), honoured only in the handler
//   flush       pipeline flush strobe
//   redirect    PC-mux override strobe, redirect_pc is 0 when it is low
//   elr, esr    saved return PC and syndrome {lost, 0, irq, opcode}
//   in_handler  handler running
//   exc_count   exceptions taken, saturating at 8'hFF
module exc_ctrl #(
  parameter int N = 64,
  parameter logic [N-1:0] EXC_VECTOR = N'(64'hD4)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         exc_req,
  input  logic [N-1:0] exc_pc,
  input  logic         ext_irq,
  input  logic         eret,
  output logic         flush,
  output logic         redirect,
  output logic [N-1:0] redirect_pc,
  output logic [N-1:0] elr,
  output logic [3:0]   esr,
  output logic         in_handler,
  output logic [7:0]   exc_count
);
  typedef enum logic [1:0] {IDLE, FLUSH, HANDLER, RET} state_t;
  state_t state, state_nxt;
  logic take;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    take = (state == IDLE) && (exc_req || ext_irq);
    state_nxt = take ? FLUSH :
                (state == FLUSH) ? HANDLER :
                (state == HANDLER && eret) ? RET :
                (state == RET) ? IDLE : state;
  end
  // On capture an opcode exception wins over a simultaneous interrupt; the
  // interrupt is a level and is taken again after the return. The lost sticky
  // bit survives every capture.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      elr <= '0;
      esr <= '0;
      exc_count <= '0;
    end else if (take) begin
      elr <= exc_pc;
      esr <= {esr[3], 1'b0, ~exc_req, exc_req};
      if (exc_count != 8'hFF) exc_count <= exc_count + 8'd1;
    end else if (state == HANDLER && exc_req) begin
      esr[3] <= 1'b1;
    end
  // Outputs decode state and registers only, so reset clears them at once.
  assign flush       = (state == FLUSH) || (state == RET);
  assign redirect    = flush;
  assign in_handler  = (state == HANDLER);
  assign redirect_pc = (state == FLUSH) ? EXC_VECTOR :
                       (state == RET) ? (esr[0] ? elr + N'(4) : elr) : '0;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl with directed entry/return sequences.
module tb_exc_ctrl;
  logic        clk = 1'b0, reset = 1'b0, exc_req = 1'b0, ext_irq = 1'b0, eret = 1'b0;
  logic [63:0] exc_pc = '0;
  logic        flush, redirect, in_handler;
  logic [63:0] redirect_pc, elr;
  logic [3:0]  esr;
  logic [7:0]  exc_count;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_pc(exc_pc), .ext_irq(ext_irq),
    .eret(eret), .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .elr(elr), .esr(esr), .in_handler(in_handler), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] lr;
    logic [3:0]  sr;
    logic [7:0]  cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, n_exc = 0;
  logic [63:0] lelr;
  logic [3:0]  les;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] sat();
    return (n_exc > 255) ? 8'hFF : 8'(n_exc);
  endfunction

  // Monitor: every redirect pulse must match the oldest expected one.
  always @(negedge clk) begin
    if (reset && redirect !== 1'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_redirect actual_pc=%0h required=no_redirect", redirect_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("redirect_pc", redirect_pc, e.pc);
        chk("flush", {63'd0, flush}, 64'd1);
        chk("elr", elr, e.lr);
        chk("esr", {60'd0, esr}, {60'd0, e.sr});
        chk("exc_count", {56'd0, exc_count}, {56'd0, e.cnt});
      end
    end
  end

  // Raise a request in IDLE; returns at the negedge inside FLUSH.
  task automatic issue(input logic e, input logic i, input logic [63:0] pc, input logic [3:0] es);
    exc_req = e;
    ext_irq = i;
    exc_pc = pc;
    n_exc++;
    lelr = pc;
    les = es;
    q.push_back('{64'hD4, pc, es, sat()});
    @(negedge clk);
    exc_req = 1'b0;
    ext_irq = 1'b0;
  endtask

  // From FLUSH or HANDLER: issue ERET, expect return to pc, end in IDLE.
  task automatic ret(input logic [63:0] pc);
    @(negedge clk);
    chk("in_handler_hi", {63'd0, in_handler}, 64'd1);
    chk("no_redirect_handler", {63'd0, redirect}, 64'd0);
    eret = 1'b1;
    q.push_back('{pc, lelr, les, sat()});
    @(negedge clk);
    eret = 1'b0;
    @(negedge clk);
    chk("in_handler_lo", {63'd0, in_handler}, 64'd0);
    chk("idle_redirect_pc", redirect_pc, 64'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_flush"}, {63'd0, flush}, 64'd0);
    chk({nm, "_redirect"}, {63'd0, redirect}, 64'd0);
    chk({nm, "_redirect_pc"}, redirect_pc, 64'd0);
    chk({nm, "_elr"}, elr, 64'd0);
    chk({nm, "_esr"}, {60'd0, esr}, 64'd0);
    chk({nm, "_in_handler"}, {63'd0, in_handler}, 64'd0);
    chk({nm, "_exc_count"}, {56'd0, exc_count}, 64'd0);
  endtask

  initial begin
    #1 chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 1'b0, 64'h20, 4'h1);
    ret(64'h24);
    issue(1'b0, 1'b1, 64'h40, 4'h2);
    ret(64'h40);
    issue(1'b1, 1'b1, 64'h80, 4'h1);
    ext_irq = 1'b1;
    exc_pc = 64'h90;
    ret(64'h84);
    n_exc++;
    lelr = 64'h90;
    les = 4'h2;
    q.push_back('{64'hD4, 64'h90, 4'h2, sat()});
    @(negedge clk);
    ext_irq = 1'b0;
    ret(64'h90);
    issue(1'b1, 1'b0, 64'h100, 4'h1);
    @(negedge clk);
    exc_req = 1'b1;
    exc_pc = 64'h200;
    @(negedge clk);
    exc_req = 1'b0;
    chk("lost_elr", elr, 64'h100);
    chk("lost_esr", {60'd0, esr}, 64'h9);
    chk("lost_no_redirect", {63'd0, redirect}, 64'd0);
    les = 4'h9;
    ret(64'h104);
    issue(1'b0, 1'b1, 64'h300, 4'hA);
    ret(64'h300);
    issue(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 4'h9);
    ret(64'h0);
    for (int i = 0; i < 250; i++) begin
      issue(1'b1, 1'b0, 64'(i * 8), 4'h9);
      ret(64'(i * 8 + 4));
    end
    chk("count_saturated", {56'd0, exc_count}, 64'hFF);
    issue(1'b1, 1'b0, 64'h500, 4'h9);
    @(negedge clk);
    chk("in_handler_before_reset", {63'd0, in_handler}, 64'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_zero("abort");
    n_exc = 0;
    @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 1'b0, 64'h600, 4'h1);
    ret(64'h604);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_redirects actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
